// File: rtl/timer_multi_pkg.sv
// Shared types and register map for the multi-channel bus timer.
// Channel/master FSM states, register offsets and bit positions.
package timer_multi_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_FETCH = 2'd1,
    CH_RUN   = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_READ = 2'd2
  } m_state_e;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_LOAD_ADDR = 2'd1;
  localparam logic [1:0] REG_STATUS    = 2'd2;
  localparam logic [1:0] REG_COUNT     = 2'd3;
  localparam logic [7:0] PRESCALE_ADDR = 8'hF0;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;

  localparam int ST_PEND  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_FETCH = 2;

endpackage

// File: rtl/timer_multi_ch.sv
// One timer channel: CTRL/LOAD_ADDR/LOAD/COUNT/PEND, channel FSM, expiry.
// Ports: register write strobes + data, tick, load delivery, read views, irq.
module timer_multi_ch
  import timer_multi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_laddr,
  input  logic             wr_status,
  input  logic [7:0]       wdata,
  input  logic             tick,
  input  logic             load_vld,
  input  logic [CNT_W-1:0] load_val,
  input  logic             served,
  output logic [7:0]       ctrl_o,
  output logic [7:0]       laddr_o,
  output logic [7:0]       status_o,
  output logic [7:0]       count_o,
  output logic             fetch_req,
  output logic             irq
);

  ch_state_e        st_q, st_d;
  logic             en_q, en_d;
  logic             per_q, per_d;
  logic             ie_q, ie_d;
  logic             pend_q, pend_d;
  logic [7:0]       laddr_q, laddr_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    st_d    = st_q;
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    laddr_d = laddr_q;
    load_d  = load_q;
    count_d = count_q;
    if (wr_ctrl) begin
      en_d  = wdata[CTRL_EN];
      per_d = wdata[CTRL_PER];
      ie_d  = wdata[CTRL_IE];
    end
    if (wr_laddr) laddr_d = wdata;
    if (wr_status && wdata[ST_PEND]) pend_d = 1'b0;
    unique case (st_q)
      CH_IDLE: begin
        if (wr_ctrl && wdata[CTRL_EN] && !en_q) st_d = CH_FETCH;
      end
      CH_FETCH: begin
        // A fetch already owned by the master must finish before
        // an abandoned channel may drop back to idle.
        if (load_vld) begin
          if (en_d) begin
            st_d    = CH_RUN;
            load_d  = load_val;
            count_d = load_val;
          end else begin
            st_d = CH_IDLE;
          end
        end else if (!en_d && !served) begin
          st_d = CH_IDLE;
        end
      end
      CH_RUN: begin
        if (!en_d) begin
          st_d = CH_IDLE;
        end else if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else begin
            pend_d = 1'b1;
            if (per_d) begin
              count_d = load_q;
            end else begin
              en_d = 1'b0;
              st_d = CH_IDLE;
            end
          end
        end
      end
      default: st_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= CH_IDLE;
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      laddr_q <= '0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      laddr_q <= laddr_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  assign ctrl_o    = {5'b0, ie_q, per_q, en_q};
  assign laddr_o   = laddr_q;
  assign status_o  = {5'b0, st_q == CH_FETCH, st_q == CH_RUN, pend_q};
  assign count_o   = count_q[7:0];
  assign fetch_req = (st_q == CH_FETCH) && en_q;
  assign irq       = pend_q && ie_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: prescaler, load-fetch bus master, register file.
// Ports: slave S_* register bus, master M_* read port, ORed interrupt.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       S_sel,
  input  logic [7:0] S_address,
  input  logic       S_wr,
  input  logic [7:0] S_din,
  output logic [7:0] S_dout,
  output logic       M_req,
  input  logic       M_grant,
  output logic [7:0] M_address,
  output logic       M_wr,
  output logic [7:0] M_dout,
  input  logic [7:0] M_din,
  output logic       interrupt
);

  localparam int NB = CNT_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_en, rd_en, wr_pre, tick;
  logic [7:0]       pre_q, pre_d;
  logic [7:0]       scale_q, scale_d;
  logic [7:0]       rdata;

  logic [NUM_CH-1:0] wr_ctrl, wr_la, wr_st;
  logic [NUM_CH-1:0] ld_vld, served, freq, irq;
  logic [7:0]        ctrl_r [NUM_CH];
  logic [7:0]        la_r   [NUM_CH];
  logic [7:0]        st_r   [NUM_CH];
  logic [7:0]        cnt_r  [NUM_CH];

  m_state_e         m_st_q, m_st_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [7:0]       base_q, base_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [CNT_W-1:0] buf_q, buf_d;
  logic             done;

  assign wr_en  = S_sel && S_wr;
  assign rd_en  = S_sel && !S_wr;
  assign wr_pre = wr_en && (S_address == PRESCALE_ADDR);
  assign tick   = (pre_q == scale_q);

  always_comb begin
    scale_d = scale_q;
    pre_d   = tick ? 8'h00 : pre_q + 8'h01;
    if (wr_pre) begin
      scale_d = S_din;
      pre_d   = 8'h00;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (S_address == PRESCALE_ADDR) rdata = scale_q;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i] = wr_en && (S_address == {6'(i), REG_CTRL});
      wr_la[i]   = wr_en && (S_address == {6'(i), REG_LOAD_ADDR});
      wr_st[i]   = wr_en && (S_address == {6'(i), REG_STATUS});
      if (S_address[7:2] == 6'(i)) begin
        unique case (S_address[1:0])
          REG_CTRL:      rdata = ctrl_r[i];
          REG_LOAD_ADDR: rdata = la_r[i];
          REG_STATUS:    rdata = st_r[i];
          REG_COUNT:     rdata = cnt_r[i];
          default:       rdata = 8'h00;
        endcase
      end
    end
  end

  assign S_dout = rd_en ? rdata : 8'h00;

  always_comb begin
    m_st_d = m_st_q;
    ch_d   = ch_q;
    base_d = base_q;
    byte_d = byte_q;
    buf_d  = buf_q;
    done   = 1'b0;
    unique case (m_st_q)
      M_IDLE: begin
        // Descending scan leaves the lowest requester selected.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (freq[i]) begin
            ch_d   = CW'(i);
            base_d = la_r[i];
            byte_d = '0;
            m_st_d = M_REQ;
          end
        end
      end
      M_REQ: begin
        if (M_grant) m_st_d = M_READ;
      end
      M_READ: begin
        if (M_grant) begin
          for (int b = 0; b < NB; b++) begin
            if (byte_q == BW'(b)) buf_d[8*b +: 8] = M_din;
          end
          if (byte_q == BW'(NB - 1)) begin
            done   = 1'b1;
            m_st_d = M_IDLE;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      default: m_st_d = M_IDLE;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      served[i] = (m_st_q != M_IDLE) && (ch_q == CW'(i));
      ld_vld[i] = done && (ch_q == CW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      scale_q <= '0;
      m_st_q  <= M_IDLE;
      ch_q    <= '0;
      base_q  <= '0;
      byte_q  <= '0;
      buf_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      scale_q <= scale_d;
      m_st_q  <= m_st_d;
      ch_q    <= ch_d;
      base_q  <= base_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_multi_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (wr_ctrl[g]),
      .wr_laddr  (wr_la[g]),
      .wr_status (wr_st[g]),
      .wdata     (S_din),
      .tick      (tick),
      .load_vld  (ld_vld[g]),
      .load_val  (buf_d),
      .served    (served[g]),
      .ctrl_o    (ctrl_r[g]),
      .laddr_o   (la_r[g]),
      .status_o  (st_r[g]),
      .count_o   (cnt_r[g]),
      .fetch_req (freq[g]),
      .irq       (irq[g])
    );
  end

  assign M_req     = (m_st_q != M_IDLE);
  assign M_address = (m_st_q == M_READ) ? base_q + 8'(byte_q) : 8'h00;
  assign M_wr      = 1'b0;
  assign M_dout    = 8'h00;
  assign interrupt = |irq;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi (NUM_CH=2, CNT_W=16).
// Bus memory model on the master port, hand-computed expectations.
module tb_timer_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_sel = 1'b0;
  logic [7:0] s_addr = '0;
  logic       s_wr = 1'b0;
  logic [7:0] s_din = '0;
  logic [7:0] s_dout;
  logic       m_req;
  logic       gnt = 1'b1;
  logic [7:0] m_addr;
  logic       m_wr;
  logic [7:0] m_dout;
  logic [7:0] m_din;
  logic       irq;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_din = gnt ? mem[m_addr] : 8'hEE;

  timer_multi #(.NUM_CH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .S_sel     (s_sel),
    .S_address (s_addr),
    .S_wr      (s_wr),
    .S_din     (s_din),
    .S_dout    (s_dout),
    .M_req     (m_req),
    .M_grant   (gnt),
    .M_address (m_addr),
    .M_wr      (m_wr),
    .M_dout    (m_dout),
    .M_din     (m_din),
    .interrupt (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic wait_irq(output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (irq) begin
        ok = 1'b1;
        c = cyc;
        return;
      end
    end
  endtask

  logic [7:0] d;
  logic [7:0] log_a [4];
  int n_log, c1, c2;
  bit ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h03; mem[8'h21] = 8'h00;
    mem[8'h40] = 8'h02; mem[8'h41] = 8'h00;
    mem[8'h30] = 8'h34; mem[8'h31] = 8'h12;
    mem[8'h50] = 8'hCD; mem[8'h51] = 8'hAB;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_mreq", m_req, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_mwr", {m_wr, m_dout}, 9'h0);
    rd(8'h00, d); chk("rst_ctrl0", d, 8'h00);
    rd(8'hF0, d); chk("rst_pre", d, 8'h00);

    // one-shot ch0, LOAD=3, prescale 0
    wr(8'h01, 8'h20);
    wr(8'hF0, 8'h00);
    wr(8'h00, 8'h05);
    rd(8'h02, d); chk("t1_fetch", d, 8'h04);
    chk("t1_noreq", m_req, 1'b0);
    @(negedge clk); chk("t1_req", m_req, 1'b1);
    @(negedge clk); chk("t1_a0", m_addr, 8'h20);
    @(negedge clk); chk("t1_a1", m_addr, 8'h21);
    @(negedge clk);
    rd(8'h02, d); chk("t1_run", d, 8'h02);
    rd(8'h03, d); chk("t1_cnt", d, 8'h03);
    chk("t1_reqdn", m_req, 1'b0);
    repeat (3) @(negedge clk);
    rd(8'h02, d); chk("t1_notyet", d, 8'h02);
    chk("t1_irq0", irq, 1'b0);
    @(negedge clk);
    rd(8'h02, d); chk("t1_pend", d, 8'h01);
    chk("t1_irq1", irq, 1'b1);
    rd(8'h00, d); chk("t1_en0", d, 8'h04);
    wr(8'h02, 8'h01);
    chk("t1_irqclr", irq, 1'b0);

    // periodic ch1, LOAD=2, prescale 1
    wr(8'hF0, 8'h01);
    wr(8'h05, 8'h40);
    wr(8'h04, 8'h07);
    wait_irq(c1, ok); chk("t2_irq_a", ok, 1'b1);
    wr(8'h06, 8'h01);
    chk("t2_w1c", irq, 1'b0);
    wait_irq(c2, ok); chk("t2_irq_b", ok, 1'b1);
    chk("t2_period", c2 - c1, 6);
    wr(8'h04, 8'h00);
    wr(8'h06, 8'h01);
    rd(8'h06, d); chk("t2_off", d, 8'h00);

    // both channels queued, fixed priority
    gnt = 1'b0;
    wr(8'hF0, 8'hFF);
    wr(8'h05, 8'h30);
    wr(8'h00, 8'h01);
    wr(8'h04, 8'h01);
    gnt = 1'b1;
    n_log = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_addr != 8'h00 && n_log < 4) begin
        log_a[n_log] = m_addr;
        n_log++;
      end
    end
    chk("t3_nbytes", n_log, 4);
    chk("t3_b0", log_a[0], 8'h20);
    chk("t3_b1", log_a[1], 8'h21);
    chk("t3_b2", log_a[2], 8'h30);
    chk("t3_b3", log_a[3], 8'h31);
    rd(8'h03, d); chk("t3_cnt0", d, 8'h03);
    rd(8'h07, d); chk("t3_cnt1", d, 8'h34);
    rd(8'h06, d); chk("t3_run1", d, 8'h02);
    wr(8'h00, 8'h00);
    wr(8'h04, 8'h00);

    // grant withheld, then toggled mid-read
    wr(8'hF0, 8'hFF);
    wr(8'h01, 8'h50);
    gnt = 1'b0;
    wr(8'h00, 8'h01);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", m_req, 1'b1);
      @(negedge clk);
    end
    gnt = 1'b1;
    @(negedge clk); gnt = 1'b0;
    chk("t4_r0n", {m_req, m_addr}, 9'h150);
    @(negedge clk); gnt = 1'b1;
    chk("t4_r0g", {m_req, m_addr}, 9'h150);
    @(negedge clk); gnt = 1'b0;
    chk("t4_r1n", {m_req, m_addr}, 9'h151);
    @(negedge clk); gnt = 1'b1;
    chk("t4_r1g", {m_req, m_addr}, 9'h151);
    @(negedge clk);
    chk("t4_done", m_req, 1'b0);
    rd(8'h03, d); chk("t4_cnt", d, 8'hCD);
    wr(8'h00, 8'h00);

    // W1C colliding with expiry, then a plain W1C
    wr(8'h01, 8'h20);
    wr(8'hF0, 8'h00);
    wr(8'h00, 8'h01);
    repeat (6) @(negedge clk);
    wr(8'h02, 8'h01);
    rd(8'h02, d); chk("t5_hwwins", d, 8'h01);
    wr(8'h02, 8'h01);
    rd(8'h02, d); chk("t5_w1c", d, 8'h00);

    // EN cleared while the fetch is pending on the bus
    gnt = 1'b0;
    wr(8'h00, 8'h01);
    @(negedge clk);
    wr(8'h00, 8'h00);
    rd(8'h02, d); chk("t5_infetch", d, 8'h04);
    gnt = 1'b1;
    repeat (4) @(negedge clk);
    rd(8'h02, d); chk("t5_idle", d, 8'h00);
    rd(8'h03, d); chk("t5_cnt0", d, 8'h00);
    chk("t5_noreq", m_req, 1'b0);

    // reset in the middle of a fetch
    wr(8'h00, 8'h01);
    repeat (2) @(negedge clk);
    chk("t6_pre", m_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_mreq", m_req, 1'b0);
    chk("t6_maddr", m_addr, 8'h00);
    rd(8'h00, d); chk("t6_ctrl", d, 8'h00);
    rd(8'h01, d); chk("t6_la", d, 8'h00);
    rd(8'h02, d); chk("t6_st", d, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    wr(8'h01, 8'h20);
    wr(8'h00, 8'h01);
    repeat (4) @(negedge clk);
    rd(8'h02, d); chk("t6_run", d, 8'h02);
    rd(8'h03, d); chk("t6_cnt", d, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
